// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare next-fetch-address predictor.
// - pred_state_e   : init sequencer states
// - counter_init   : weakly-not-taken counter reset value for a given width
// - pc_index/pc_tag: fetch-address to table index / BTB tag mapping
// Helpers return 32-bit values; callers size-cast to their table widths.
package gshare_predictor_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } pred_state_e;

  // Weakly not-taken: 2^(cw-1) - 1, e.g. 2'b01 for a 2-bit counter.
  function automatic logic [31:0] counter_init(input int unsigned cw);
    return (32'd1 << (cw - 1)) - 32'd1;
  endfunction

  // Word-aligned index: pc[iw+1:2].
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned iw);
    return (pc >> 2) & ((32'd1 << iw) - 32'd1);
  endfunction

  // Tag: pc[31:iw+2].
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned iw);
    return pc >> (iw + 2);
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Training bundle from the execute/commit stage into the predictor.
// - valid  : an update is presented this cycle
// - pc     : fetch address of the resolved instruction
// - is_br  : instruction is a conditional/direct branch
// - taken  : resolved direction
// - target : resolved target (meaningful when taken)
// master drives the bundle, slave (the predictor) consumes it.
interface IUpdatePredictionIO;
  logic        valid;
  logic [31:0] pc;
  logic        is_br;
  logic        taken;
  logic [31:0] target;

  modport master (output valid, pc, is_br, taken, target);
  modport slave  (input  valid, pc, is_br, taken, target);
endinterface

// File: rtl/gshare_predictor_sat_counter_update.sv
// Combinational saturating up/down counter step.
// - cur   : current counter value
// - taken : 1 steps toward all-ones, 0 steps toward zero
// - nxt   : next value, clamped at both ends (never wraps)
module sat_counter_update #(
  parameter int unsigned COUNTER_WIDTH = 2
) (
  input  logic [COUNTER_WIDTH-1:0] cur,
  input  logic                     taken,
  output logic [COUNTER_WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != '1) nxt = cur + COUNTER_WIDTH'(1);
    end else begin
      if (cur != '0) nxt = cur - COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare next-fetch-address predictor with tagged BTB and speculative GHR.
// - clk, rst_n        : clock, asynchronous active-low reset
// - pc                : fetch address to predict (combinational lookup)
// - pred_fire         : fetch consumed the prediction; shifts speculative history
// - next_pc           : predicted next fetch address
// - pred_taken        : prediction is a taken branch
// - pred_history      : GHR used for this lookup, piped back as update_history
// - ready             : init sequencer finished clearing the tables
// - updateio          : training bundle (valid, pc, is_br, taken, target)
// - update_history    : GHR captured when the updated instruction was fetched
// - update_mispredict : update carries a direction/target misprediction
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 6,
  parameter int unsigned COUNTER_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc,
  input  logic                     pred_fire,
  output logic [31:0]              next_pc,
  output logic                     pred_taken,
  output logic [HISTORY_WIDTH-1:0] pred_history,
  output logic                     ready,
  IUpdatePredictionIO.slave        updateio,
  input  logic [HISTORY_WIDTH-1:0] update_history,
  input  logic                     update_mispredict
);

  localparam int unsigned Entries  = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = 30 - INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CntInit = COUNTER_WIDTH'(counter_init(COUNTER_WIDTH));
  localparam logic [INDEX_WIDTH-1:0]   IdxLast = '1;

  // Tables. No reset on the arrays: the init sequencer clears valid bits and
  // counters, and tag/target are never observed while their valid bit is 0.
  logic [COUNTER_WIDTH-1:0] pht        [Entries];
  logic [TagWidth-1:0]      btb_tag    [Entries];
  logic [31:0]              btb_target [Entries];
  logic [Entries-1:0]       btb_valid;

  pred_state_e              state_q;
  logic [INDEX_WIDTH-1:0]   init_ptr_q;
  logic                     ready_q;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;

  // Lookup path
  logic [INDEX_WIDTH-1:0]   lk_bidx, lk_pidx;
  logic [TagWidth-1:0]      lk_tag;
  logic                     lk_hit;
  logic [COUNTER_WIDTH-1:0] lk_ctr;

  assign lk_bidx = INDEX_WIDTH'(pc_index(pc, INDEX_WIDTH));
  assign lk_tag  = TagWidth'(pc_tag(pc, INDEX_WIDTH));
  assign lk_pidx = lk_bidx ^ INDEX_WIDTH'(ghr_q);
  assign lk_hit  = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  assign lk_ctr  = pht[lk_pidx];

  assign ready        = ready_q;
  assign pred_taken   = ready_q && lk_hit && lk_ctr[COUNTER_WIDTH-1];
  assign next_pc      = pred_taken ? btb_target[lk_bidx] : pc + 32'd4;
  assign pred_history = ghr_q;

  // Update path: indices come from the history seen at fetch, not the current GHR.
  logic                     upd_en;
  logic [INDEX_WIDTH-1:0]   up_bidx, up_pidx;
  logic [TagWidth-1:0]      up_tag;
  logic                     up_tag_hit;
  logic [COUNTER_WIDTH-1:0] up_ctr_cur, up_ctr_nxt;

  assign upd_en     = ready_q && updateio.valid;
  assign up_bidx    = INDEX_WIDTH'(pc_index(updateio.pc, INDEX_WIDTH));
  assign up_tag     = TagWidth'(pc_tag(updateio.pc, INDEX_WIDTH));
  assign up_pidx    = up_bidx ^ INDEX_WIDTH'(update_history);
  assign up_tag_hit = btb_valid[up_bidx] && (btb_tag[up_bidx] == up_tag);
  assign up_ctr_cur = pht[up_pidx];

  sat_counter_update #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_sat_counter_update (
    .cur  (up_ctr_cur),
    .taken(updateio.taken),
    .nxt  (up_ctr_nxt)
  );

  // Recovery overrides the speculative shift when both happen in one cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (ready_q && pred_fire) begin
      ghr_d = HISTORY_WIDTH'({ghr_q, pred_taken});
    end
    if (upd_en && update_mispredict) begin
      if (updateio.is_br) begin
        ghr_d = HISTORY_WIDTH'({update_history, updateio.taken});
      end else begin
        ghr_d = update_history;
      end
    end
  end

  // Init sequencer and history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
      ghr_q      <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_ptr_q <= init_ptr_q + INDEX_WIDTH'(1);
          if (init_ptr_q == IdxLast) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          ready_q <= 1'b1;
        end
      endcase
      ghr_q <= ghr_d;
    end
  end

  // Table writes. BTB and PHT are separate arrays, so a branch update writes both.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      btb_valid[init_ptr_q] <= 1'b0;
      pht[init_ptr_q]       <= CntInit;
    end else if (upd_en) begin
      if (updateio.is_br) begin
        btb_valid[up_bidx] <= 1'b1;
        btb_tag[up_bidx]   <= up_tag;
        if (updateio.taken) btb_target[up_bidx] <= updateio.target;
        pht[up_pidx] <= up_ctr_nxt;
      end else if (up_tag_hit) begin
        // A non-branch living at this pc evicts the stale branch entry.
        btb_valid[up_bidx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  localparam int KNpc   = 0;
  localparam int KTaken = 1;
  localparam int KHist  = 2;
  localparam int KReady = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pred_fire;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [5:0]  pred_history;
  logic        ready;
  logic [5:0]  update_history;
  logic        update_mispredict;

  IUpdatePredictionIO upd ();

  gshare_predictor #(
    .INDEX_WIDTH  (6),
    .HISTORY_WIDTH(6),
    .COUNTER_WIDTH(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc               (pc),
    .pred_fire        (pred_fire),
    .next_pc          (next_pc),
    .pred_taken       (pred_taken),
    .pred_history     (pred_history),
    .ready            (ready),
    .updateio         (upd),
    .update_history   (update_history),
    .update_mispredict(update_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      KNpc:    return next_pc;
      KTaken:  return {31'd0, pred_taken};
      KHist:   return {26'd0, pred_history};
      default: return {31'd0, ready};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.kind);
      checks++;
      assert (got === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a lookup address and compare the combinational prediction.
  task automatic probe(input string tag, input logic [31:0] pcv, input logic [31:0] npc,
                       input logic tk);
    pc = pcv;
    expect_out({tag, "_npc"}, KNpc, npc);
    expect_out({tag, "_taken"}, KTaken, {31'd0, tk});
    #1;
    check_all();
  endtask

  task automatic probe_hist(input string tag, input logic [5:0] h);
    expect_out(tag, KHist, {26'd0, h});
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_update(input logic [31:0] pcv, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic [5:0] hist,
                           input logic misp, input logic fire);
    upd.valid         = 1'b1;
    upd.pc            = pcv;
    upd.is_br         = br;
    upd.taken         = tk;
    upd.target        = tgt;
    update_history    = hist;
    update_mispredict = misp;
    pred_fire         = fire;
    tick();
    upd.valid         = 1'b0;
    update_mispredict = 1'b0;
    pred_fire         = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    #1;
  endtask

  int n;

  initial begin
    rst_n             = 1'b0;
    pc                = 32'h100;
    pred_fire         = 1'b0;
    upd.valid         = 1'b0;
    upd.pc            = '0;
    upd.is_br         = 1'b0;
    upd.taken         = 1'b0;
    upd.target        = '0;
    update_history    = '0;
    update_mispredict = 1'b0;

    // Reset state
    #3;
    expect_out("rst_ready", KReady, 0);
    expect_out("rst_hist", KHist, 0);
    probe("rst", 32'h100, 32'h104, 1'b0);

    // Traffic during init must be ignored
    upd.valid         = 1'b1;
    upd.pc            = 32'h200;
    upd.is_br         = 1'b1;
    upd.taken         = 1'b1;
    upd.target        = 32'h80;
    update_history    = 6'h3F;
    update_mispredict = 1'b1;
    pred_fire         = 1'b1;
    #8;
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin
        expect_out("init_npc", KNpc, 32'h104);
        expect_out("init_taken", KTaken, 0);
        expect_out("init_ready", KReady, 0);
        expect_out("init_hist", KHist, 0);
        check_all();
      end
    end
    check_eq("init_cycles", n, 64);
    upd.valid         = 1'b0;
    update_mispredict = 1'b0;
    pred_fire         = 1'b0;
    #1;
    expect_out("post_init_ready", KReady, 1);
    probe_hist("post_init_hist", 6'h00);
    probe("post_init_200", 32'h200, 32'h204, 1'b0);

    // Training at 0x200 under history 0; same-cycle lookup sees old entry
    upd.valid = 1'b1; upd.pc = 32'h200; upd.is_br = 1'b1; upd.taken = 1'b1;
    upd.target = 32'h80; update_history = 6'h00;
    probe("write_old", 32'h200, 32'h204, 1'b0);
    tick();
    upd.valid = 1'b0;
    probe("t1_10", 32'h200, 32'h80, 1'b1);
    do_update(32'h200, 1, 1, 32'h80, 6'h00, 0, 0);
    probe("t2_11", 32'h200, 32'h80, 1'b1);
    do_update(32'h200, 1, 0, 32'h0, 6'h00, 0, 0);
    probe("nt1_10", 32'h200, 32'h80, 1'b1);
    do_update(32'h200, 1, 0, 32'h0, 6'h00, 0, 0);
    probe("nt2_01", 32'h200, 32'h204, 1'b0);
    do_update(32'h200, 1, 0, 32'h0, 6'h00, 0, 0);
    probe("nt3_00", 32'h200, 32'h204, 1'b0);
    do_update(32'h200, 1, 0, 32'h0, 6'h00, 0, 0);
    do_update(32'h200, 1, 1, 32'h80, 6'h00, 0, 0);
    probe("sat0_01", 32'h200, 32'h204, 1'b0);
    do_update(32'h200, 1, 1, 32'h80, 6'h00, 0, 0);
    probe("retrain_10", 32'h200, 32'h80, 1'b1);

    // Alias and BTB invalidation
    probe("alias_1200", 32'h1200, 32'h1204, 1'b0);
    do_update(32'h1200, 0, 0, 32'h0, 6'h00, 0, 0);
    probe("nonbr_alias_keep", 32'h200, 32'h80, 1'b1);
    do_update(32'h200, 0, 0, 32'h0, 6'h00, 0, 0);
    probe("nonbr_clear", 32'h200, 32'h204, 1'b0);

    // Recovery: train 0x340 (bidx 16) taken under histories 0, 1, 3
    do_update(32'h340, 1, 1, 32'h500, 6'h00, 0, 0);
    do_update(32'h340, 1, 1, 32'h500, 6'h01, 0, 0);
    do_update(32'h340, 1, 1, 32'h500, 6'h03, 0, 0);
    pred_fire = 1'b1;
    expect_out("fire0_hist", KHist, 6'h00);
    probe("fire0", 32'h340, 32'h500, 1'b1);
    tick();
    expect_out("fire1_hist", KHist, 6'h01);
    probe("fire1", 32'h340, 32'h500, 1'b1);
    tick();
    expect_out("fire2_hist", KHist, 6'h03);
    probe("fire2", 32'h340, 32'h500, 1'b1);
    tick();
    pred_fire = 1'b0;
    probe_hist("ghr_000111", 6'h07);
    probe("ghr7_lookup", 32'h340, 32'h344, 1'b0);
    do_update(32'h340, 1, 0, 32'h0, 6'h03, 1, 0);
    probe_hist("recover_000110", 6'h06);
    do_update(32'h340, 1, 0, 32'h0, 6'h03, 1, 1);
    probe_hist("recover_beats_fire", 6'h06);
    do_update(32'h7000, 0, 0, 32'h0, 6'h2A, 1, 0);
    probe_hist("nonbr_recover", 6'h2A);
    pc = 32'h340;
    do_update(32'h7000, 0, 0, 32'h0, 6'h00, 0, 1);
    probe_hist("fire_no_misp", 6'h14);

    // Gshare separation at 0x480 (bidx 32)
    do_update(32'h480, 1, 1, 32'h900, 6'h00, 0, 0);
    do_update(32'h480, 1, 0, 32'h0, 6'h01, 0, 0);
    do_update(32'h7000, 0, 0, 32'h0, 6'h00, 1, 0);
    probe("gs_hist0", 32'h480, 32'h900, 1'b1);
    do_update(32'h7000, 0, 0, 32'h0, 6'h01, 1, 0);
    probe("gs_hist1", 32'h480, 32'h484, 1'b0);

    // Async reset in RUN after training
    do_update(32'h7000, 0, 0, 32'h0, 6'h00, 1, 0);
    do_update(32'h200, 1, 1, 32'h80, 6'h00, 0, 0);
    probe("pre_rst_200", 32'h200, 32'h80, 1'b1);
    pred_fire = 1'b1;
    tick();
    pred_fire = 1'b0;
    probe_hist("pre_rst_hist", 6'h01);
    rst_n = 1'b0;
    #1;
    expect_out("arst_ready", KReady, 0);
    expect_out("arst_hist", KHist, 0);
    probe("arst", 32'h200, 32'h204, 1'b0);
    #3;
    rst_n = 1'b1;
    wait_ready(n);
    check_eq("reinit_cycles", n, 64);
    expect_out("reinit_ready", KReady, 1);
    probe("reinit_200", 32'h200, 32'h204, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Next-fetch-address predictor for the fetch stage. It is the parametrised successor to the direct-mapped two-bit BTB/counter block, adding four things:
- a gshare pattern history table (PC XOR global history) with configurable counter width;
- a tagged, valid-bit BTB;
- a speculative global history register with misprediction recovery;
- a self-clearing init sequencer.

Lookup is combinational, as before. Training arrives from the execute/commit stage over the existing update interface.

## Interface
Parameters:
- INDEX_WIDTH, 6: log2 entries of both the PHT and the BTB.
- HISTORY_WIDTH, 6: global history bits, ≤ INDEX_WIDTH.
- COUNTER_WIDTH, 2: saturating counter width, ≥ 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- pc  input  32  fetch address to predict.
- pred_fire  input  1  fetch consumed this cycle's prediction. Shifts the speculative history.
- next_pc  output  32  predicted next fetch address.
- pred_taken  output  1  prediction is a taken branch.
- pred_history  output  HISTORY_WIDTH  GHR value used for this lookup. The core pipes it to update_history.
- ready  output  1  init complete.
- updateio  input  IUpdatePredictionIO  valid, pc, is_br, taken, target.
- update_history  input  HISTORY_WIDTH  pred_history captured when the updated instruction was fetched.
- update_mispredict  input  1  qualifies updateio.valid. Direction or target was wrong.

## Operation
- Index mapping:
  - bidx = pc[INDEX_WIDTH+1:2].
  - pidx = bidx XOR zero-extended GHR.
  - tag = pc[31:INDEX_WIDTH+2].
- Hit: BTB valid[bidx] and tag equal.
- Prediction:
  - pred_taken = ready AND hit AND pht[pidx] MSB.
  - next_pc = pred_taken ? btb_target[bidx] : pc + 4, with 32-bit wrap.
- Speculative GHR: when pred_fire and ready, ghr <= {ghr[H-2:0], pred_taken}.
- Update, only when ready and updateio.valid. Update indices are computed from updateio.pc and update_history.
  - is_br = 0:
    - if the BTB tag matches, clear valid;
    - PHT untouched;
    - GHR untouched unless update_mispredict is set, in which case ghr <= update_history.
  - is_br = 1, BTB:
    - write tag and set valid;
    - write target only when taken.
  - is_br = 1, PHT: saturating ±1 toward taken.
    - Saturates at all-ones and at zero.
    - Counter arithmetic is COUNTER_WIDTH bits with no wrap.
  - is_br = 1 and update_mispredict: ghr <= {update_history[H-2:0], updateio.taken}.
- Counter init value: weakly not-taken, 2^(COUNTER_WIDTH-1) − 1 (01 for width 2).
- Init FSM states: INIT and RUN.
  - Reset enters INIT with init_ptr = 0.
  - Each INIT cycle writes BTB valid[init_ptr] = 0 and pht[init_ptr] = init value, then increments init_ptr.
  - At init_ptr = 2^INDEX_WIDTH − 1 the FSM moves to RUN.
  - ready = (state == RUN).

## Timing
- Reset values: state = INIT, init_ptr = 0, ghr = 0, ready = 0.
  - Therefore pred_taken = 0, next_pc = pc + 4, pred_history = 0.
- Init lasts exactly 2^INDEX_WIDTH cycles after rst_n deasserts. ready rises on the following edge.
- During INIT, updateio and pred_fire are ignored. Table contents are only guaranteed once ready = 1.
- Reset asserted mid-INIT or mid-RUN: asynchronous return to INIT, GHR cleared, init restarts from 0.
- Lookup is zero-latency combinational.
- Writes land on the rising edge. A same-cycle lookup of the entry being written sees the old value.
- pred_fire and a mispredict update in the same cycle: the recovery value wins and the speculative shift is dropped.
- Update without mispredict: GHR untouched. The speculative shift from pred_fire still applies.
- BTB and PHT updates in one cycle touch different arrays. No conflict.

## Structure
- Shared package: init constant function of COUNTER_WIDTH; pc-to-index/tag helper functions; FSM state enum.
- IUpdatePredictionIO is reused unchanged.
- One sub-module: sat_counter_update. It is combinational and returns the next value from (cur, taken, COUNTER_WIDTH). It is reusable by later tournament predictors.

## Test plan
- Reset then idle: ready = 0 for 64 cycles (defaults), 1 on cycle 65. During init, next_pc = pc + 4 for pc = 0x100 → 0x104.
- Train branch at pc 0x200, target 0x80, history 0: first update (taken) → counter 10 → next_pc = 0x80. A second taken update saturates at 11. Two not-taken updates → 01 → next_pc = 0x204.
- Alias check: pc 0x1200 with the same bidx as 0x200 but a different tag → miss, next_pc = 0x1204. Non-branch update at 0x200 clears valid, after which 0x200 predicts 0x204.
- Recovery: three pred_fire with pred_taken = 1 → GHR 000111. Mispredict update with update_history = 000011, taken = 0 → GHR 000110. Asserting pred_fire in the same cycle still gives 000110.
- Gshare separation: same pc trained taken under history 000000 and not-taken under 000001 → each history gives its own prediction.
- Async reset during RUN after training: ready drops immediately. After re-init, previously trained pc 0x200 predicts 0x204.
